// File: rtl/vpu_spart_pkg.sv
// rtl/vpu_spart_pkg.sv - shared constants, state type and frame helpers for the keypad mask UART link
package vpu_spart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int         MASK_W           = 13;
    localparam logic       HDR_BIT          = 1'b1;
    localparam logic [1:0] TAIL_PAD         = 2'b00;
    localparam int         DEFAULT_BAUD_DIV = 2604;

    // First byte carries the marker so the receiver can find frame alignment
    function automatic logic [7:0] mask_byte0(input logic [MASK_W-1:0] m);
        return {HDR_BIT, m[12:6]};
    endfunction

    // Second byte has its MSB clear, never mistaken for a frame start
    function automatic logic [7:0] mask_byte1(input logic [MASK_W-1:0] m);
        return {TAIL_PAD, m[5:0]};
    endfunction

endpackage

// File: rtl/keypad_mask_tx_byte.sv
// rtl/keypad_mask_tx_byte.sv - 8N1 byte shifter with baud counter and go/done handshake
module uart_tx_byte
    import vpu_spart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_go,
    input  logic [7:0] byte_data,
    output logic       byte_done,
    output logic       byte_busy,
    output logic       txd
);

    tx_state_t   state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic        bit_end;

    assign bit_end   = (baud_cnt == 16'(BAUD_DIV - 1));
    // Combinational so the sequencer can chain the next byte with no idle gap
    assign byte_done = (state == STOP) && bit_end;
    assign byte_busy = (state != IDLE);

    // Bit timing and serialisation; byte_go wins so back-to-back bytes abut exactly
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            txd       <= 1'b1;
        end else if (byte_go) begin
            state     <= START;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= byte_data;
            txd       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    txd      <= 1'b1;
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt  <= '0;
                        state     <= DATA;
                        txd       <= shift_reg[0];
                        shift_reg <= {1'b0, shift_reg[7:1]};
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            txd   <= 1'b1;
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            txd       <= shift_reg[0];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                        txd      <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/keypad_mask_tx.sv
// rtl/keypad_mask_tx.sv - two-byte framed UART transmitter for the 13-bit key mask
module keypad_mask_tx
    import vpu_spart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV,
    parameter int MASK_W   = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MASK_W-1:0] mask_in,
    input  logic              send,
    output logic              txd,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    logic              byte_go;
    logic [7:0]        byte_data;
    logic              byte_done;
    logic              byte_busy;
    logic [MASK_W-1:0] cur_mask;
    logic [MASK_W-1:0] pend_mask;
    logic              pend_vld;
    logic              byte_sel;
    logic              start_idle;
    logic              frame_end;

    assign start_idle = send && !byte_busy;
    assign frame_end  = byte_done && byte_sel;
    assign busy       = byte_busy || pend_vld;

    // Choose what the shifter loads next: fresh frame, second byte, or follow-on frame
    always_comb begin
        byte_go   = 1'b0;
        byte_data = 8'h00;
        if (start_idle) begin
            byte_go   = 1'b1;
            byte_data = mask_byte0(mask_in);
        end else if (byte_done && !byte_sel) begin
            byte_go   = 1'b1;
            byte_data = mask_byte1(cur_mask);
        end else if (frame_end && pend_vld) begin
            byte_go   = 1'b1;
            byte_data = mask_byte0(pend_mask);
        end else if (frame_end && send) begin
            byte_go   = 1'b1;
            byte_data = mask_byte0(mask_in);
        end
    end

    // Frame sequencing, one-deep pending buffer and status pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_mask  <= '0;
            pend_mask <= '0;
            pend_vld  <= 1'b0;
            byte_sel  <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            done    <= frame_end;
            overrun <= 1'b0;
            if (start_idle) begin
                cur_mask <= mask_in;
                byte_sel <= 1'b0;
            end else if (byte_done && !byte_sel) begin
                byte_sel <= 1'b1;
            end else if (frame_end) begin
                byte_sel <= 1'b0;
                if (pend_vld) begin
                    cur_mask <= pend_mask;
                    // A send landing here refills the buffer the pending mask just left
                    if (send) begin
                        pend_mask <= mask_in;
                    end else begin
                        pend_vld <= 1'b0;
                    end
                end else if (send) begin
                    cur_mask <= mask_in;
                end
            end
            // Mid-frame request: latest key state wins, flag the one it displaced
            if (send && byte_busy && !frame_end) begin
                pend_mask <= mask_in;
                pend_vld  <= 1'b1;
                overrun   <= pend_vld;
            end
        end
    end

    uart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx_byte (
        .clk       (clk),
        .rst_n     (rst_n),
        .byte_go   (byte_go),
        .byte_data (byte_data),
        .byte_done (byte_done),
        .byte_busy (byte_busy),
        .txd       (txd)
    );

endmodule

// File: tb/tb_keypad_mask_tx.sv
// tb/tb_keypad_mask_tx.sv - self-checking bench for keypad_mask_tx at BAUD_DIV=4
module tb_keypad_mask_tx;

    localparam int BD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        send = 1'b0;
    logic [12:0] mask_in = 13'h0;
    logic        txd, busy, done, overrun;

    keypad_mask_tx #(.BAUD_DIV(BD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mask_in (mask_in),
        .send    (send),
        .txd     (txd),
        .busy    (busy),
        .done    (done),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: independent 8N1 decoder sampling mid-bit, plus pulse counters
    logic [7:0] rxq[$];
    int         start_q[$];
    int         done_q[$];
    int         done_cnt = 0;
    int         ovr_cnt = 0;
    int         stop_err = 0;
    bit         rx_active = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            rx_active = 1'b0;
        end else begin
            if (done) begin
                done_cnt++;
                done_q.push_back(cyc);
            end
            if (overrun) ovr_cnt++;
            if (!rx_active) begin
                if (txd == 1'b0) begin
                    rx_active = 1'b1;
                    rx_cnt    = 0;
                    start_q.push_back(cyc);
                end
            end else begin
                rx_cnt++;
                if ((rx_cnt % BD) == 2 && (rx_cnt / BD) >= 1 && (rx_cnt / BD) <= 8)
                    rx_sh[(rx_cnt / BD) - 1] = txd;
                if (rx_cnt == 9 * BD + 2) begin
                    if (txd != 1'b1) stop_err++;
                    rxq.push_back(rx_sh);
                    rx_active = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_rx(input string nm, input int idx, input logic [7:0] exp);
        logic [31:0] act;
        act = (idx < rxq.size()) ? {24'h0, rxq[idx]} : 32'hDEAD_BEEF;
        chk(nm, act, {24'h0, exp});
    endtask

    task automatic clear_mon();
        rxq.delete();
        start_q.delete();
        done_q.delete();
        ovr_cnt  = 0;
        stop_err = 0;
    endtask

    // Called at a negedge; the send is sampled at the next posedge
    task automatic pulse_send(input logic [12:0] m);
        mask_in = m;
        send    = 1'b1;
        @(negedge clk);
        send    = 1'b0;
        mask_in = 13'($urandom);
    endtask

    task automatic wait_done(input int n, input int budget, input string nm);
        int k;
        k = 0;
        while (done_cnt < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk(nm, 32'(done_cnt >= n), 32'd1);
        @(negedge clk);
    endtask

    // Full single frame from idle: waveform bit-for-bit, done timing, decoded bytes
    task automatic run_frame(input logic [12:0] m, input logic [7:0] b0, input logic [7:0] b1,
                             input string nm);
        logic [19:0] exp_bits;
        int          bad;
        int          d0;
        exp_bits = {1'b1, b1, 1'b0, 1'b1, b0, 1'b0};
        bad      = 0;
        clear_mon();
        d0 = done_cnt;
        pulse_send(m);
        for (int k = 0; k < 20 * BD; k++) begin
            if (txd !== exp_bits[k / BD]) bad++;
            if (done !== 1'b0) bad++;
            @(negedge clk);
        end
        chk({nm, "_wave"}, 32'(bad), 32'd0);
        chk({nm, "_done"}, {31'h0, done}, 32'd1);
        chk({nm, "_busy_low"}, {31'h0, busy}, 32'd0);
        #1;
        chk({nm, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
        chk_rx({nm, "_b0"}, 0, b0);
        chk_rx({nm, "_b1"}, 1, b1);
        chk({nm, "_nbytes"}, 32'(rxq.size()), 32'd2);
        chk({nm, "_stop"}, 32'(stop_err), 32'd0);
        @(negedge clk);
    endtask

    typedef struct {
        logic [12:0] mask;
        logic [7:0]  b0;
        logic [7:0]  b1;
        string       nm;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int d0;
        int lows;

        vecs[0] = '{13'h1A5C, 8'hE9, 8'h1C, "m1A5C"};
        vecs[1] = '{13'h1FFF, 8'hFF, 8'h3F, "m1FFF"};
        vecs[2] = '{13'h0000, 8'h80, 8'h00, "m0000"};
        vecs[3] = '{13'h0040, 8'h81, 8'h00, "m0040"};
        vecs[4] = '{13'h003F, 8'h80, 8'h3F, "m003F"};
        vecs[5] = '{13'h1555, 8'hD5, 8'h15, "m1555"};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_txd", {31'h0, txd}, 32'd1);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_done", {31'h0, done}, 32'd0);
        chk("rst_overrun", {31'h0, overrun}, 32'd0);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // mask_in wiggling without send must not start anything
        mask_in = 13'h1234;
        repeat (5) @(negedge clk);
        chk("nosend_busy", {31'h0, busy}, 32'd0);
        chk("nosend_txd", {31'h0, txd}, 32'd1);

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].mask, vecs[i].b0, vecs[i].b1, vecs[i].nm);
        end

        // Follow-on send at +10: second frame abuts the first, no overrun
        clear_mon();
        d0 = done_cnt;
        pulse_send(13'h0001);
        repeat (9) @(negedge clk);
        pulse_send(13'h0002);
        wait_done(d0 + 2, 400, "b2b_timeout");
        chk_rx("b2b_b0", 0, 8'h80);
        chk_rx("b2b_b1", 1, 8'h01);
        chk_rx("b2b_b2", 2, 8'h80);
        chk_rx("b2b_b3", 3, 8'h02);
        chk("b2b_done_gap", (done_q.size() >= 2) ? 32'(done_q[1] - done_q[0]) : 32'hFFFF, 32'd80);
        chk("b2b_start_gap", (start_q.size() >= 3) ? 32'(start_q[2] - start_q[1]) : 32'hFFFF, 32'd40);
        chk("b2b_overrun", 32'(ovr_cnt), 32'd0);
        repeat (10) @(negedge clk);
        chk("b2b_idle_busy", {31'h0, busy}, 32'd0);

        // Three sends during one frame: two overruns, only the last follows
        clear_mon();
        d0 = done_cnt;
        pulse_send(13'h1A5C);
        repeat (9) @(negedge clk);
        pulse_send(13'h0003);
        repeat (9) @(negedge clk);
        pulse_send(13'h0004);
        repeat (9) @(negedge clk);
        pulse_send(13'h0005);
        wait_done(d0 + 2, 400, "ovr_timeout");
        repeat (100) @(negedge clk);
        chk("ovr_count", 32'(ovr_cnt), 32'd2);
        chk("ovr_nbytes", 32'(rxq.size()), 32'd4);
        chk_rx("ovr_b0", 0, 8'hE9);
        chk_rx("ovr_b1", 1, 8'h1C);
        chk_rx("ovr_b2", 2, 8'h80);
        chk_rx("ovr_b3", 3, 8'h05);
        chk("ovr_done_cnt", 32'(done_cnt - d0), 32'd2);
        chk("ovr_idle_busy", {31'h0, busy}, 32'd0);

        // Send landing exactly in the frame-completion cycle with nothing pending
        clear_mon();
        d0 = done_cnt;
        pulse_send(13'h1FFF);
        repeat (20 * BD - 1) @(negedge clk);
        pulse_send(13'h0000);
        chk("dcyc_done", {31'h0, done}, 32'd1);
        chk("dcyc_txd_start", {31'h0, txd}, 32'd0);
        chk("dcyc_busy", {31'h0, busy}, 32'd1);
        lows = 0;
        for (int k = 0; k < 20 * BD - 1; k++) begin
            @(negedge clk);
            if (busy !== 1'b1) lows++;
        end
        chk("dcyc_busy_held", 32'(lows), 32'd0);
        @(negedge clk);
        chk("dcyc_done2", {31'h0, done}, 32'd1);
        chk("dcyc_busy_end", {31'h0, busy}, 32'd0);
        #1;
        chk_rx("dcyc_b0", 0, 8'hFF);
        chk_rx("dcyc_b1", 1, 8'h3F);
        chk_rx("dcyc_b2", 2, 8'h80);
        chk_rx("dcyc_b3", 3, 8'h00);
        chk("dcyc_overrun", 32'(ovr_cnt), 32'd0);
        @(negedge clk);

        // Reset 30 cycles into a frame: line idles, no done, clean frame afterwards
        clear_mon();
        d0 = done_cnt;
        pulse_send(13'h1A5C);
        repeat (29) @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rstmid_txd", {31'h0, txd}, 32'd1);
        chk("rstmid_busy", {31'h0, busy}, 32'd0);
        #1 rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("rstmid_no_done", 32'(done_cnt - d0), 32'd0);
        chk("rstmid_no_bytes", 32'(rxq.size()), 32'd0);
        chk("rstmid_txd_idle", {31'h0, txd}, 32'd1);
        run_frame(13'h1A5C, 8'hE9, 8'h1C, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute time limit so the run always ends on its own
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/keypad_mask_tx.md
Name: keypad_mask_tx

Overview:
- UART transmitter for the 13-bit key bit-mask; it is the far end of the link whose receiver drives bit_mask and bit_mask_ready into the CPU.
- Used on the companion keypad board and as the stimulus source in the full-system bench.
- Serialises each mask as a two-byte 8N1 frame with a first-byte marker, so the receiver can resynchronise after a truncated byte.
- Holds one pending mask so key changes that arrive mid-frame are not lost.

Parameters:
- BAUD_DIV, 2604, clk cycles per bit (50 MHz / 19200 baud); legal range 2..65535.
- MASK_W, 13, key mask width; fixed by frame format, must not be overridden.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- mask_in  in  13  key bit-mask; sampled only in a cycle where send=1.
- send  in  1  single-cycle request to transmit mask_in.
- txd  out  1  serial line; idles high.
- busy  out  1  high while a frame is on the line or a mask is pending.
- done  out  1  one-cycle pulse when the final stop bit of a frame completes.
- overrun  out  1  one-cycle pulse when a valid pending mask is overwritten.

Behaviour:
- Reset values: txd=1, busy=0, done=0, overrun=0; pending_vld=0; FSM=IDLE; counters=0.
- Frame format:
  - byte0 = {1'b1, mask[12:6]}; byte1 = {2'b00, mask[5:0]}.
  - Each byte is 8N1: start bit 0, data LSB first, one stop bit 1.
  - Frame = 20 bit times = 20*BAUD_DIV cycles.
- FSM states and transitions:
  - IDLE -> START on send (mask latched into shift register).
  - START -> DATA after BAUD_DIV cycles.
  - DATA: 8 bits, each BAUD_DIV cycles, bit index 0..7; -> STOP after bit 7.
  - STOP, after BAUD_DIV cycles: if byte_sel=0, go to START with byte_sel=1. If byte_sel=1, pulse done, then:
    - pending_vld=1: START with the pending mask, byte_sel=0, pending_vld cleared.
    - else, send=1 this cycle: START with mask_in.
    - else: IDLE.
- Latency:
  - send sampled at edge N -> txd=0 from edge N+1.
  - done asserted in cycle N+20*BAUD_DIV+1.
  - With a follow-on frame there is no idle gap between stop bit and next start bit.
- txd is registered, glitch-free, and changes only on bit boundaries.
- Pending buffer, send while FSM≠IDLE and not frame-completion:
  - pending_vld=0: latch into pending.
  - pending_vld=1: overwrite (latest key state wins) and pulse overrun.
- Send in the frame-completion cycle:
  - pending_vld=0: starts immediately, no overrun.
  - pending_vld=1: pending mask goes out; new mask goes into pending, no overrun.
- busy = (FSM≠IDLE) | pending_vld; it drops in the cycle the FSM returns to IDLE.
- mask_in changes without send have no effect; an in-flight frame is never altered.
- Baud counter is 16 bits; it reloads to 0 at each bit boundary and never wraps mid-bit.
- Reset mid-frame: next edge forces txd=1, IDLE, pending cleared, no done pulse. The receiver discards the partial byte and resyncs on the next byte with MSB=1.

Decomposition:
- Package vpu_spart_pkg holds:
  - FSM state enum {IDLE, START, DATA, STOP}.
  - MASK_W=13.
  - Marker constants HDR_BIT=1'b1 (byte0 MSB) and TAIL_PAD=2'b00.
  - Default BAUD_DIV, shared with the receiver's baud generator.
- One natural sub-module, uart_tx_byte: 8N1 shifter plus baud counter with a byte_go/byte_done handshake. keypad_mask_tx keeps the frame sequencing, byte_sel and the pending register.

Test Plan (BAUD_DIV=4, frame=80 cycles):
- Idle, send with mask_in=13'h1A5C:
  - bytes 0xE9 then 0x1C on txd.
  - first byte bits 0,1,0,0,1,0,1,1,1,1, each 4 cycles.
  - done at send+81; busy low at send+81.
- Boundary masks:
  - 13'h1FFF -> 0xFF, 0x3F.
  - 13'h0000 -> 0x80, 0x00.
- send 13'h0001, then send 13'h0002 at +10 cycles:
  - second frame (0x80, 0x02) starts with zero idle gap.
  - two done pulses 80 cycles apart; overrun never asserted.
- Three sends during one frame (13'h0003, 13'h0004, 13'h0005):
  - overrun pulses twice.
  - only 13'h0005 (0x80, 0x05) follows.
- send exactly in the done cycle with pending empty: new frame's start bit begins the next cycle; busy stays high throughout.
- rst_n low for 1 cycle at +30 cycles into a frame:
  - txd=1, busy=0 the following cycle; no done pulse.
  - a subsequent send of 13'h1A5C transmits a clean 0xE9, 0x1C.
